// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and helper functions
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int FRAME_WIDTH        = DEFAULT_DATA_WIDTH + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    function automatic int cycles_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Parity bit the transmitter appends; data narrower than 32 bits is zero-extended.
    function automatic logic parity_bit(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - receiver-side byte/status bundle between uart_rx and its consumer
interface uart_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] RxData;
    logic                  valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    modport master (output RxData, valid, parity_err, frame_err, busy);
    modport slave  (input  RxData, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser with selectable reset level
module uart_sync #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, MSB-first data, parity, stop; mid-bit sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic RxD,
    uart_if.master rx
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam int BIT_W          = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic                  rxs;
    rx_state_t             state, state_n;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err_q;
    logic                  tick;
    logic                  load_half, load_bit, shift_en, par_en, stop_en;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RxD),
        .q     (rxs)
    );

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Entry to IDLE only happens with the line high, so a low rxs here is a fresh falling edge.
    always_comb begin
        state_n   = state;
        load_half = 1'b0;
        load_bit  = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_n   = S_START;
                    load_half = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n  = S_DATA;
                        load_bit = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    load_bit = 1'b1;
                    if (bit_idx == LAST_BIT) state_n = S_PARITY;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_en   = 1'b1;
                    load_bit = 1'b1;
                    state_n  = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    stop_en = 1'b1;
                    state_n = rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            par_err_q     <= 1'b0;
            rx.RxData     <= '0;
            rx.valid      <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            if (load_half)     cnt <= CNT_HALF;
            else if (load_bit) cnt <= CNT_BIT;
            else if (!tick)    cnt <= cnt - CNT_W'(1);

            if (load_half)     bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + BIT_W'(1);

            if (shift_en) shreg <= {shreg[DATA_WIDTH-2:0], rxs};
            if (par_en)   par_err_q <= (parity_bit(32'(shreg), PARITY_ODD) != rxs);

            // Outputs move together so the consumer sees a coherent byte/flag set on valid.
            rx.valid <= stop_en;
            if (stop_en) begin
                rx.RxData     <= shreg;
                rx.parity_err <= par_err_q;
                rx.frame_err  <= ~rxs;
            end

            rx.busy <= (state_n inside {S_DATA, S_PARITY, S_STOP, S_BREAK});
        end
    end

endmodule
